// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - pipeline and data_memory signals seen by the store buffer
// master drives requests and memory read data; slave is the buffer itself.
interface store_buffer_if;
  logic        MemRead_in;
  logic        MemWrite_in;
  logic [31:0] adr_in;
  logic [31:0] data_in;
  logic [31:0] rdata_out;
  logic        stall_out;
  logic        empty;
  logic [31:0] mem_adr;
  logic [31:0] mem_wdata;
  logic        mem_MemRead;
  logic        mem_MemWrite;
  logic [31:0] mem_rdata;

  modport master (
    output MemRead_in, MemWrite_in, adr_in, data_in, mem_rdata,
    input  rdata_out, stall_out, empty, mem_adr, mem_wdata, mem_MemRead, mem_MemWrite
  );

  modport slave (
    input  MemRead_in, MemWrite_in, adr_in, data_in, mem_rdata,
    output rdata_out, stall_out, empty, mem_adr, mem_wdata, mem_MemRead, mem_MemWrite
  );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - FIFO write buffer in front of data_memory with load forwarding
// Stores drain through the single memory port whenever a load miss is not using it.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic          clk,
  input  logic          rst,
  store_buffer_if.slave bus
);

  logic [31:0]      r_adr  [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic        w_load;
  logic        w_store;
  logic        w_full;
  logic        w_hit;
  logic [31:0] w_hit_data;
  logic        w_miss;
  logic        w_drain;
  logic        w_enq;

  assign w_load  = bus.MemRead_in & ~bus.MemWrite_in;
  assign w_store = bus.MemWrite_in;
  assign w_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign w_miss  = w_load & ~w_hit;
  assign w_drain = (r_count != '0) & ~w_miss;
  assign w_enq   = w_store & ~w_full;

  // Walk entries oldest to youngest so the last match found is the youngest store.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((PTR_W+1)'(i) < r_count) &&
          (r_adr[r_head + PTR_W'(i)][11:2] == bus.adr_in[11:2])) begin
        w_hit      = 1'b1;
        w_hit_data = r_data[r_head + PTR_W'(i)];
      end
    end
  end

  // Everything is quiet during reset so no pending store can reach memory.
  always_comb begin
    bus.rdata_out    = '0;
    bus.stall_out    = 1'b0;
    bus.mem_adr      = '0;
    bus.mem_wdata    = '0;
    bus.mem_MemRead  = 1'b0;
    bus.mem_MemWrite = 1'b0;
    if (!rst) begin
      bus.stall_out = w_store & w_full;
      if (w_load) begin
        bus.rdata_out = w_hit ? w_hit_data : bus.mem_rdata;
      end
      if (w_miss) begin
        bus.mem_MemRead = 1'b1;
        bus.mem_adr     = bus.adr_in;
      end else if (w_drain) begin
        bus.mem_MemWrite = 1'b1;
        bus.mem_adr      = r_adr[r_head];
        bus.mem_wdata    = r_data[r_head];
      end
    end
  end

  assign bus.empty = (r_count == '0);

  always_ff @(posedge clk) begin
    if (!rst && w_enq) begin
      r_adr[r_tail]  <= bus.adr_in;
      r_data[r_tail] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_drain) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_enq, w_drain})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - randomized bench for store_buffer against a queue-based model
// Includes a behavioural data_memory and directed scenarios with literal expectations.
module tb_store_buffer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] data;
  } ent_t;

  logic clk;
  logic rst;
  store_buffer_if sb ();

  store_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] tb_mem  [1024];
  logic [31:0] ref_mem [1024];

  assign sb.mem_rdata = tb_mem[sb.mem_adr[11:2]];

  always @(posedge clk) begin
    if (sb.mem_MemWrite) tb_mem[sb.mem_adr[11:2]] <= sb.mem_wdata;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  ent_t        q[$];
  logic [31:0] drain_log[$];
  bit          model_on = 1'b0;
  int          ncyc = 0;

  logic        m_load, m_store, m_hit, m_miss, m_drain;
  logic [31:0] m_hdata, e_rdata, e_adr, e_wdata;

  // Compare process: derive expected outputs from the queue of pending stores.
  always @(negedge clk) begin
    if (model_on) begin
      if (sb.mem_MemWrite) drain_log.push_back(sb.mem_adr);
      if (ncyc > 0) chk("empty", sb.empty, (q.size() == 0));
      if (rst) begin
        chk("rst_rdata", sb.rdata_out, 0);
        chk("rst_stall", sb.stall_out, 0);
        chk("rst_memrd", sb.mem_MemRead, 0);
        chk("rst_memwr", sb.mem_MemWrite, 0);
        q.delete();
      end else begin
        m_load  = sb.MemRead_in && !sb.MemWrite_in;
        m_store = sb.MemWrite_in;
        m_hit   = 1'b0;
        m_hdata = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
          if (q[i].adr[11:2] == sb.adr_in[11:2]) begin
            m_hit   = 1'b1;
            m_hdata = q[i].data;
            break;
          end
        end
        m_miss  = m_load && !m_hit;
        m_drain = (q.size() > 0) && !m_miss;
        e_rdata = !m_load ? 32'h0 : (m_hit ? m_hdata : ref_mem[sb.adr_in[11:2]]);
        e_adr   = m_miss ? sb.adr_in : (m_drain ? q[0].adr : 32'h0);
        e_wdata = m_drain ? q[0].data : 32'h0;
        chk("rdata", sb.rdata_out, e_rdata);
        chk("stall", sb.stall_out, m_store && (q.size() == DEPTH));
        chk("memrd", sb.mem_MemRead, m_miss);
        chk("memwr", sb.mem_MemWrite, m_drain);
        chk("mem_adr", sb.mem_adr, e_adr);
        if (!m_miss) chk("mem_wdata", sb.mem_wdata, e_wdata);
        if (m_store && q.size() < DEPTH) q.push_back('{adr: sb.adr_in, data: sb.data_in});
        if (m_drain) begin
          ref_mem[q[0].adr[11:2]] = q[0].data;
          void'(q.pop_front());
        end
      end
      ncyc++;
    end
  end

  task automatic drive(input logic r, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    rst            = r;
    sb.MemRead_in  = rd;
    sb.MemWrite_in = wr;
    sb.adr_in      = a;
    sb.data_in     = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  int          nbad;
  logic [31:0] ra, rd_val;
  logic [31:0] exp_order[5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h40};

  initial begin
    for (int i = 0; i < 1024; i++) begin
      tb_mem[i]  = 32'hA5A5_0000 + i;
      ref_mem[i] = 32'hA5A5_0000 + i;
    end
    rst = 1'b1;
    sb.MemRead_in = 1'b1; sb.MemWrite_in = 1'b1;
    sb.adr_in = 32'hFFFF_FFFC; sb.data_in = 32'h1234_5678;
    model_on = 1'b1;
    @(negedge clk);

    drive(1'b1, 1'b1, 1'b1, 32'h0000_0ABC, 32'hCAFE_F00D);
    chk("lit_rst_rdata", sb.rdata_out, 32'h0);
    chk("lit_rst_memwr", sb.mem_MemWrite, 32'h0);
    idle(1);
    chk("lit_empty_after_rst", sb.empty, 32'h1);

    drive(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    idle(1);
    chk("lit_drain_wr", sb.mem_MemWrite, 32'h1);
    chk("lit_drain_adr", sb.mem_adr, 32'h10);
    chk("lit_drain_data", sb.mem_wdata, 32'hDEAD_BEEF);
    idle(1);
    chk("lit_empty_after_drain", sb.empty, 32'h1);
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    chk("lit_miss_rdata", sb.rdata_out, 32'hDEAD_BEEF);

    drive(1'b0, 1'b0, 1'b1, 32'h20, 32'h1111);
    drive(1'b0, 1'b0, 1'b1, 32'h20, 32'h2222);
    drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
    chk("lit_fwd_rdata", sb.rdata_out, 32'h2222);
    chk("lit_fwd_memrd", sb.mem_MemRead, 32'h0);
    chk("lit_fwd_stall", sb.stall_out, 32'h0);
    idle(3);
    drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
    chk("lit_fwd_mem", sb.rdata_out, 32'h2222);

    idle(2);
    drain_log.delete();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
      if (i == 0) chk("lit_miss_0x100", sb.rdata_out, 32'hA5A5_0040);
      drive(1'b0, 1'b0, 1'b1, 32'(4 * i), 32'h5000 + 32'(i));
    end
    drive(1'b0, 1'b0, 1'b1, 32'h40, 32'h5004);
    idle(3);
    chk("lit_drain_count", 32'(drain_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < drain_log.size(); i++) chk("lit_drain_order", drain_log[i], exp_order[i]);

    drive(1'b0, 1'b0, 1'b1, 32'h30, 32'h3333);
    drive(1'b0, 1'b1, 1'b0, 32'h200, 32'h0);
    chk("lit_blk_memrd", sb.mem_MemRead, 32'h1);
    chk("lit_blk_memwr", sb.mem_MemWrite, 32'h0);
    chk("lit_blk_adr", sb.mem_adr, 32'h200);
    idle(1);
    chk("lit_blk_drain_adr", sb.mem_adr, 32'h30);

    idle(1);
    drive(1'b0, 1'b0, 1'b1, 32'h50, 32'h7777);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("lit_midrst_memwr", sb.mem_MemWrite, 32'h0);
    idle(1);
    chk("lit_midrst_empty", sb.empty, 32'h1);
    drive(1'b0, 1'b1, 1'b0, 32'h50, 32'h0);
    chk("lit_midrst_rdata", sb.rdata_out, 32'hA5A5_0014);

    for (int n = 0; n < 3000; n++) begin
      ra = $urandom;
      ra[11:2] = 10'($urandom_range(0, 7));
      ra[1:0] = 2'b00;
      rd_val = $urandom;
      drive(($urandom_range(0, 199) == 0), 1'($urandom), ($urandom_range(0, 2) == 0), ra, rd_val);
    end

    idle(8);
    nbad = 0;
    for (int i = 0; i < 1024; i++) if (tb_mem[i] !== ref_mem[i]) nbad++;
    chk("final_mem", nbad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
